hazard_control: RTL
===================

// Module: hazard_control
// PURPOSE
//  Sequences the decode stage: holds PC and IF/ID on load-use hazards, inserts
//  bubbles into ID/EX, flushes IF/ID when decode resolves a taken branch. Keeps a
//  2-entry scoreboard of issued instructions (EX, MEM slots). Sits beside
//  decode_stage, driving the PC and pipeline-register enables.
// PARAMETERS
//  CNT_W   32  width of stall/flush performance counters (saturating)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      reset, asynchronous, active-high
//  id_valid       in   1      IF/ID register holds a real instruction
//  id_rs1         in   5      decode source register 1
//  id_rs2         in   5      decode source register 2
//  id_uses_rs1    in   1      instruction reads rs1
//  id_uses_rs2    in   1      instruction reads rs2
//  id_rd          in   5      decode destination register
//  id_reg_write   in   1      instruction writes rd
//  id_mem_read    in   1      instruction is a load
//  id_is_branch   in   1      control.encoding == B_TYPE
//  id_pc_src      in   1      PCSrc from decode (branch taken)
//  ext_stall      in   1      back-end freeze (memory busy)
//  pc_write       out  1      1 = PC loads next value
//  ifid_write     out  1      1 = IF/ID register loads
//  ifid_flush     out  1      1 = IF/ID register loads a bubble (valid=0)
//  idex_bubble    out  1      1 = ID/EX register loads control all-zero
//  hz_state       out  2      hazard_state_t: RUN/STALL/FLUSH/FROZEN
//  stall_cycles   out  CNT_W  cycles with hazard stall asserted
//  flush_count    out  CNT_W  taken-branch flushes
// BEHAVIOUR
//  - Scoreboard slots ex_q, mem_q = sb_entry_t{valid,rd,reg_write,mem_read}.
//    Each edge, when ext_stall=0: mem_q<=ex_q; ex_q<=issued ID entry if
//    id_valid&&!stall, else valid=0. When ext_stall=1: all registers hold.
//  - dep(s) = s.valid && s.reg_write && s.rd!=0 && ((id_uses_rs1&&id_rs1==s.rd)
//    || (id_uses_rs2&&id_rs2==s.rd)). Matches against x0 never stall.
//  - load_use = dep(ex_q) && ex_q.mem_read; stall = id_valid && (load_use||br_haz).
//  - Outputs are combinational, zero latency. Priority: rst > ext_stall > stall > flush.
//    ext_stall: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
//    stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
//    taken (id_valid&&id_pc_src&&!stall): pc_write=1, ifid_write=1, ifid_flush=1.
//    Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
//  - A branch that stalls must not flush. Its id_pc_src is ignored until the stall
//    clears. A taken branch under ext_stall is deferred: ID holds it, so it
//    re-evaluates on the next unfrozen cycle.
//  - hz_state is registered and reflects the previous cycle's decision:
//    FROZEN if ext_stall, else STALL if stall, else FLUSH if taken, else RUN.
//  - Counters: stall_cycles +1 per edge with stall&&!ext_stall.
//    flush_count +1 per taken flush. Both saturate at all-ones, no wrap.
//  - Reset (asynchronous, any time, including mid-stall): scoreboard valid=0,
//    hz_state=RUN, counters=0. While rst=1: pc_write=1, ifid_write=1,
//    ifid_flush=0, idex_bubble=0.
// CONFIGURATION
//  HAZARD_BRANCH_STALL_EN defined: decode compares branch operands, so
//    br_haz = id_is_branch && (dep(ex_q) || (dep(mem_q)&&mem_q.mem_read)).
//    ALU producer costs 1 stall cycle; load producer costs 2.
//  Undefined: br_haz=0. Branches stall only on load_use, like other instructions.
// STRUCTURE
//  common package: hazard_state_t enum, sb_entry_t struct.
//  Sub-module hazard_scoreboard: 2-slot shift register with hold and insert-bubble.
// TESTING
//  1 lw x5 in ID, then add x6,x5,x1 -> 1 cycle pc_write=0, idex_bubble=1;
//    stall_cycles=1; hz_state=STALL the following cycle.
//  2 lw x0 then add x6,x0,x1 -> no stall (x0 exempt).
//  3 beq taken, no dependency -> ifid_flush=1 one cycle; flush_count=1.
//  4 addi x7 then beq x7,x7 -> with macro: 1 stall, then flush.
//    Without macro: no stall, immediate flush.
//  5 lw x8 then beq x8,x0 (macro on) -> 2 stall cycles, then flush;
//    stall_cycles=2.
//  6 ext_stall=1 for 3 cycles during a load-use stall -> enables held,
//    hz_state=FROZEN, counters frozen. Then rst pulse mid-stall -> all cleared.

Source files
------------

// File: rtl/hazard_control_pkg.sv
// Shared types for the decode-stage hazard controller: hazard state encoding,
// scoreboard entry layout and the source-operand dependency test.
package hazard_control_pkg;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'd0,
      HZ_STALL  = 2'd1,
      HZ_FLUSH  = 2'd2,
      HZ_FROZEN = 2'd3
   } hazard_state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } sb_entry_t;

   localparam int SB_SLOTS = 2;

   // Writes to x0 are architecturally discarded, so they never create a dependency.
   function automatic logic dep(input sb_entry_t s,
                                input logic uses_rs1, input logic [4:0] rs1,
                                input logic uses_rs2, input logic [4:0] rs2);
      return s.valid && s.reg_write && (s.rd != 5'd0) &&
             ((uses_rs1 && (rs1 == s.rd)) || (uses_rs2 && (rs2 == s.rd)));
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot shift register tracking instructions issued into EX and MEM.
// Slot 0 is EX, slot 1 is MEM; the whole chain holds while the back end is frozen.
module hazard_scoreboard
   import hazard_control_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      hold,
   input  logic      issue,
   input  sb_entry_t id_entry,
   output sb_entry_t ex_q,
   output sb_entry_t mem_q
);

   sb_entry_t [SB_SLOTS-1:0] slot_reg;
   sb_entry_t [SB_SLOTS-1:0] slot_next;

   always_comb begin
      slot_next[0] = issue ? id_entry : '0;
      for (int i = 1; i < SB_SLOTS; i++) begin
         slot_next[i] = slot_reg[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_reg <= '0;
      end else if (!hold) begin
         slot_reg <= slot_next;
      end
   end

   assign ex_q  = slot_reg[0];
   assign mem_q = slot_reg[1];

endmodule

// File: rtl/hazard_control.sv
// Decode-stage hazard sequencer: PC / IF/ID enables, ID/EX bubbles, branch flushes.
// Define HAZARD_BRANCH_STALL_EN when decode compares branch operands itself.
module hazard_control
   import hazard_control_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_is_branch,
   input  logic             id_pc_src,
   input  logic             ext_stall,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output hazard_state_t    hz_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   sb_entry_t        ex_q;
   sb_entry_t        mem_q;
   sb_entry_t        id_entry;
   logic             load_use;
   logic             br_haz;
   logic             stall;
   logic             taken;
   hazard_state_t    hz_state_reg;
   hazard_state_t    hz_state_next;
   logic [CNT_W-1:0] stall_cycles_reg;
   logic [CNT_W-1:0] flush_count_reg;

   assign id_entry = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

   hazard_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .hold     (ext_stall),
      .issue    (id_valid && !stall),
      .id_entry (id_entry),
      .ex_q     (ex_q),
      .mem_q    (mem_q)
   );

   assign load_use = dep(ex_q, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2) && ex_q.mem_read;

`ifdef HAZARD_BRANCH_STALL_EN
   // Branch operands are needed in ID: wait for ALU results in EX and loads still in MEM.
   assign br_haz = id_is_branch &&
                   (dep(ex_q, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2) ||
                    (dep(mem_q, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2) && mem_q.mem_read));
`else
   logic unused_branch_inputs;
   assign unused_branch_inputs = id_is_branch ^ (^mem_q);
   assign br_haz = 1'b0;
`endif

   assign stall = id_valid && (load_use || br_haz);
   // A stalled branch has not resolved yet, so its pc_src is not trusted.
   assign taken = id_valid && id_pc_src && !stall;

   always_comb begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      hz_state_next = HZ_RUN;
      if (ext_stall) begin
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         hz_state_next = HZ_FROZEN;
      end else if (stall) begin
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         idex_bubble   = 1'b1;
         hz_state_next = HZ_STALL;
      end else if (taken) begin
         ifid_flush    = 1'b1;
         hz_state_next = HZ_FLUSH;
      end
      if (rst) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hz_state_reg     <= HZ_RUN;
         stall_cycles_reg <= '0;
         flush_count_reg  <= '0;
      end else begin
         hz_state_reg <= hz_state_next;
         if (!ext_stall && stall && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
         end
         if (!ext_stall && taken && (flush_count_reg != '1)) begin
            flush_count_reg <= flush_count_reg + 1'b1;
         end
      end
   end

   assign hz_state     = hz_state_reg;
   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;

endmodule
